// File: rtl/mac_pkg.sv
// Shared types, default sizes and arithmetic helpers for the mac_dot dot-product engine.
// Helpers work on a 64-bit container; callers cast the result down to their own width.
package mac_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int LANES_DEF   = 4;
    localparam int ACC_W_DEF   = 32;
    localparam int MAX_LEN_DEF = 256;
    localparam int EXT_W       = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Sign- or zero-extend the low w bits of v to the full container width.
    function automatic logic [EXT_W-1:0] ext_prod(input logic [EXT_W-1:0] v,
                                                  input int w,
                                                  input logic sm);
        logic [EXT_W-1:0] r;
        logic             s;
        s = 1'b0;
        for (int i = 0; i < EXT_W; i++) begin
            s = (i == w - 1) ? v[i] : s;
        end
        for (int i = 0; i < EXT_W; i++) begin
            r[i] = (i < w) ? v[i] : (sm & s);
        end
        return r;
    endfunction

    // Clamp value for a w-bit accumulator: unsigned max, or signed max/min by direction.
    function automatic logic [EXT_W-1:0] sat_val(input int w,
                                                 input logic sm,
                                                 input logic neg);
        logic [EXT_W-1:0] r;
        for (int i = 0; i < EXT_W; i++) begin
            if (i >= w) begin
                r[i] = 1'b0;
            end else if (i == w - 1) begin
                r[i] = sm ? neg : 1'b1;
            end else begin
                r[i] = sm ? ~neg : 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One registered DATA_W x DATA_W multiplier lane; signed_mode selects two's-complement operands.
// Only the low 2*DATA_W product bits are kept, which is exact for both signed and unsigned.
module mac_lane
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  en,
    input  logic                  signed_mode,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   p
);

    logic [2*DATA_W-1:0] ax_s;
    logic [2*DATA_W-1:0] bx_s;
    logic [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0] p_r;

    assign ax_s   = {{DATA_W{signed_mode & a[DATA_W-1]}}, a};
    assign bx_s   = {{DATA_W{signed_mode & b[DATA_W-1]}}, b};
    assign prod_s = ax_s * bx_s;
    assign p      = p_r;

    // Product register, loaded only on an accepted beat.
    always_ff @(posedge clk) begin
        if (aclr) begin
            p_r <= {(2*DATA_W){1'b0}};
        end else if (en) begin
            p_r <= prod_s;
        end else begin
            p_r <= p_r;
        end
    end

endmodule

// File: rtl/mac_dot.sv
// Streaming multi-lane dot-product accumulator with valid/ready on both sides.
// Optional macro MAC_DOT_SAT_EN: saturating accumulation with sticky ovf; otherwise wraps.
module mac_dot
    import mac_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LANES   = LANES_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     aclr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  mplier,
    input  logic [LANES*DATA_W-1:0]  mcand,
    input  logic                     signed_mode,
    input  logic [LEN_W-1:0]         len,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         dout,
    output logic                     ovf
);

    state_t              state_r;
    state_t              state_s;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    cnt_r;
    logic [LEN_W-1:0]    len_eff_s;
    logic                mode_r;
    logic                p_vld_r;
    logic [ACC_W-1:0]    acc_r;
    logic [ACC_W-1:0]    acc_next_s;
    logic [ACC_W-1:0]    lane_sum_s;
    logic                accept_s;
    logic                first_s;
    logic                lane_mode_s;
    logic [2*DATA_W-1:0] prod_s [LANES];

    assign accept_s    = in_valid & in_ready_r;
    assign first_s     = accept_s & (state_r == IDLE);
    assign lane_mode_s = first_s ? signed_mode : mode_r;
    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign dout        = acc_r;

    // Clamp requested length into 1..MAX_LEN.
    always_comb begin
        len_eff_s = len;
        if (len == {LEN_W{1'b0}}) begin
            len_eff_s = LEN_W'(1);
        end else if (len > LEN_W'(MAX_LEN)) begin
            len_eff_s = LEN_W'(MAX_LEN);
        end else begin
            len_eff_s = len;
        end
    end

    // Next-state logic for the beat/result handshake sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (first_s) begin
                    state_s = (len_eff_s == LEN_W'(1)) ? DRAIN : ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s && (cnt_r + LEN_W'(1) == len_r)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ACCUM;
                end
            end
            DRAIN: state_s = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, handshake outputs and beat bookkeeping.
    always_ff @(posedge clk) begin
        if (aclr) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            len_r       <= {LEN_W{1'b0}};
            cnt_r       <= {LEN_W{1'b0}};
            mode_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE) || (state_s == ACCUM);
            out_valid_r <= (state_s == HOLD);
            if (first_s) begin
                len_r  <= len_eff_s;
                cnt_r  <= LEN_W'(1);
                mode_r <= signed_mode;
            end else if (accept_s) begin
                cnt_r  <= cnt_r + LEN_W'(1);
            end else begin
                cnt_r  <= cnt_r;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mac_lane #(.DATA_W(DATA_W)) u_lane (
            .clk         (clk),
            .aclr        (aclr),
            .en          (accept_s),
            .signed_mode (lane_mode_s),
            .a           (mplier[l*DATA_W +: DATA_W]),
            .b           (mcand[l*DATA_W +: DATA_W]),
            .p           (prod_s[l])
        );
    end

    // Sum of the registered lane products at accumulator width.
    always_comb begin
        lane_sum_s = {ACC_W{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            lane_sum_s = lane_sum_s
                       + ACC_W'(ext_prod(EXT_W'(prod_s[l]), 2 * DATA_W, mode_r));
        end
    end

`ifdef MAC_DOT_SAT_EN
    logic [ACC_W:0] sum_s;
    logic           ovf_det_s;
    logic           ovf_r;

    // Overflow detection and clamping of the accumulator update.
    always_comb begin
        sum_s = {1'b0, acc_r} + {1'b0, lane_sum_s};
        if (mode_r) begin
            ovf_det_s = (acc_r[ACC_W-1] == lane_sum_s[ACC_W-1])
                      && (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
        end else begin
            ovf_det_s = sum_s[ACC_W];
        end
        if (ovf_det_s) begin
            acc_next_s = ACC_W'(sat_val(ACC_W, mode_r, acc_r[ACC_W-1]));
        end else begin
            acc_next_s = sum_s[ACC_W-1:0];
        end
    end

    // Sticky overflow flag, cleared by the first beat of the next result.
    always_ff @(posedge clk) begin
        if (aclr) begin
            ovf_r <= 1'b0;
        end else if (first_s) begin
            ovf_r <= 1'b0;
        end else if (p_vld_r && ovf_det_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`else
    // Wrapping accumulator update.
    always_comb begin
        acc_next_s = acc_r + lane_sum_s;
    end

    assign ovf = 1'b0;
`endif

    // Stage-2 accumulator; cleared on a first beat, which never coincides with a pending product.
    always_ff @(posedge clk) begin
        if (aclr) begin
            p_vld_r <= 1'b0;
            acc_r   <= {ACC_W{1'b0}};
        end else begin
            p_vld_r <= accept_s;
            if (first_s) begin
                acc_r <= {ACC_W{1'b0}};
            end else if (p_vld_r) begin
                acc_r <= acc_next_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

endmodule
